mem_mfc_unit: RTL and testbench

//  Memory subsystem consuming the load/store control strobes (MAR_EN, MDR_EN_write, MDR_EN_read,
//  MDR_out, mem_EN, mem_RW) and producing the MFC (memory-function-complete) handshake.

---
 rtl/mem_mfc_unit.sv | 119 +++++++++++
 tb/tb_mem_mfc_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_mfc_unit.sv
// Memory unit with MAR/MDR, a synchronous RAM and an MFC handshake.
// Each access is snapshotted at capture and completes after LATENCY clock edges.
module mem_mfc_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MAR_EN,
  input  logic              MDR_EN_write,
  input  logic              MDR_EN_read,
  input  logic              MDR_out,
  input  logic              mem_EN,
  input  logic              mem_RW,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              MFC,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_rw;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  logic capture;
  logic complete;
  logic ram_we;

  assign capture  = (state == IDLE) && mem_EN;
  assign complete = (state == BUSY) && mem_EN && (cnt == 4'd0);
  assign ram_we   = complete && !a_rw && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      mar   <= '0;
      mdr   <= '0;
      rdata <= '0;
      MFC   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      if (MAR_EN)
        mar <= bus_in[ADDR_W-1:0];

      // Read strobe wins over write strobe when both are asserted.
      if (MDR_EN_read)
        mdr <= rdata;
      else if (MDR_EN_write)
        mdr <= bus_in;

      case (state)
        IDLE: begin
          if (mem_EN) begin
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!mem_EN) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (a_rw)
              rdata <= ram[a_addr];
            MFC   <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          if (!mem_EN) begin
            MFC   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          MFC   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Snapshot registers and RAM array carry no reset; RAM survives rst.
  always_ff @(posedge clk) begin
    if (capture) begin
      a_addr <= mar;
      a_rw   <= mem_RW;
      a_data <= mdr;
    end
    if (ram_we)
      ram[a_addr] <= a_data;
  end

  assign bus_out   = MDR_out ? mdr : '0;
  assign bus_drive = MDR_out;

endmodule

// File: tb/tb_mem_mfc_unit.sv
// Bench for mem_mfc_unit: three instances (LATENCY 3, 1, 15) share stimulus and
// are compared each cycle against an edge-counting access model.
module tb_mem_mfc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bus_in = '0;
  logic        MAR_EN = 0, MDR_EN_write = 0, MDR_EN_read = 0, MDR_out = 1;
  logic        mem_EN = 0, mem_RW = 0;

  logic [15:0] bus_out [3];
  logic        bus_drive [3];
  logic        mfc [3];
  logic        busy [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_mfc_unit #(.DATA_W(16), .ADDR_W(8), .LATENCY(3)) u0 (
    .clk(clk), .rst(rst), .bus_in(bus_in), .MAR_EN(MAR_EN),
    .MDR_EN_write(MDR_EN_write), .MDR_EN_read(MDR_EN_read), .MDR_out(MDR_out),
    .mem_EN(mem_EN), .mem_RW(mem_RW), .bus_out(bus_out[0]),
    .bus_drive(bus_drive[0]), .MFC(mfc[0]), .busy(busy[0]));

  mem_mfc_unit #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus_in(bus_in), .MAR_EN(MAR_EN),
    .MDR_EN_write(MDR_EN_write), .MDR_EN_read(MDR_EN_read), .MDR_out(MDR_out),
    .mem_EN(mem_EN), .mem_RW(mem_RW), .bus_out(bus_out[1]),
    .bus_drive(bus_drive[1]), .MFC(mfc[1]), .busy(busy[1]));

  mem_mfc_unit #(.DATA_W(16), .ADDR_W(8), .LATENCY(15)) u2 (
    .clk(clk), .rst(rst), .bus_in(bus_in), .MAR_EN(MAR_EN),
    .MDR_EN_write(MDR_EN_write), .MDR_EN_read(MDR_EN_read), .MDR_out(MDR_out),
    .mem_EN(mem_EN), .mem_RW(mem_RW), .bus_out(bus_out[2]),
    .bus_drive(bus_drive[2]), .MFC(mfc[2]), .busy(busy[2]));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          lat_m [3] = '{3, 1, 15};
  logic [15:0] m_ram [3][256];
  logic [7:0]  m_mar [3];
  logic [15:0] m_mdr [3];
  logic [15:0] m_rdata [3];
  bit          m_mfc [3];
  bit          m_busy [3];
  int          m_since [3];
  logic [7:0]  s_addr [3];
  logic [15:0] s_data [3];
  bit          s_rw [3];
  logic [15:0] old_rd;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_mar[i] = '0; m_mdr[i] = '0; m_rdata[i] = '0;
        m_mfc[i] = 0; m_busy[i] = 0; m_since[i] = 0;
      end else begin
        old_rd = m_rdata[i];
        if (m_busy[i]) begin
          if (!mem_EN) m_busy[i] = 0;
          else begin
            m_since[i]++;
            if (m_since[i] == lat_m[i]) begin
              if (s_rw[i]) m_rdata[i] = m_ram[i][s_addr[i]];
              else         m_ram[i][s_addr[i]] = s_data[i];
              m_mfc[i]  = 1;
              m_busy[i] = 0;
            end
          end
        end else if (m_mfc[i]) begin
          if (!mem_EN) m_mfc[i] = 0;
        end else if (mem_EN) begin
          s_addr[i] = m_mar[i]; s_data[i] = m_mdr[i]; s_rw[i] = mem_RW;
          m_since[i] = 0; m_busy[i] = 1;
        end
        if (MDR_EN_read)       m_mdr[i] = old_rd;
        else if (MDR_EN_write) m_mdr[i] = bus_in;
        if (MAR_EN) m_mar[i] = bus_in[7:0];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mfc[%0d]", i),   {15'b0, mfc[i]},       {15'b0, m_mfc[i]});
      check($sformatf("busy[%0d]", i),  {15'b0, busy[i]},      {15'b0, m_busy[i]});
      check($sformatf("drive[%0d]", i), {15'b0, bus_drive[i]}, {15'b0, MDR_out});
      if (!$isunknown(m_mdr[i]))
        check($sformatf("bus_out[%0d]", i), bus_out[i], MDR_out ? m_mdr[i] : 16'h0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_mar(input logic [7:0] a);
    bus_in = {8'h00, a}; MAR_EN = 1; tick; MAR_EN = 0;
  endtask

  task automatic set_mdr(input logic [15:0] d);
    bus_in = d; MDR_EN_write = 1; tick; MDR_EN_write = 0;
  endtask

  task automatic access(input bit rw);
    int n;
    mem_EN = 1; mem_RW = rw; tick;
    mem_RW = ~rw;
    n = 0;
    while (!mfc[0] && n < 40) begin tick; n++; end
    check("latency_main", 16'(n), 16'd3);
    if (rw) begin MDR_EN_read = 1; tick; MDR_EN_read = 0; end
    check("mfc_held", {15'b0, mfc[0]}, 16'd1);
    mem_EN = 0; tick;
    check("mfc_fall", {15'b0, mfc[0]}, 16'd0);
  endtask

  task automatic store(input logic [7:0] a, input logic [15:0] d);
    set_mar(a); set_mdr(d); access(0);
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] exp, input string name);
    set_mar(a); access(1);
    check(name, bus_out[0], exp);
  endtask

  task automatic sweep(input bit rw);
    int first [3];
    first = '{-1, -1, -1};
    mem_EN = 1; mem_RW = rw; tick;
    for (int n = 1; n <= 20; n++) begin
      tick;
      for (int i = 0; i < 3; i++)
        if (mfc[i] && first[i] < 0) first[i] = n;
    end
    check("sweep_lat3",  16'(first[0]), 16'd3);
    check("sweep_lat1",  16'(first[1]), 16'd1);
    check("sweep_lat15", 16'(first[2]), 16'd15);
    if (rw) begin MDR_EN_read = 1; tick; MDR_EN_read = 0; end
    mem_EN = 0; tick;
  endtask

  initial begin
    #1 rst = 1;
    tick; tick;
    check("reset_mfc",  {15'b0, mfc[0]},  16'd0);
    check("reset_busy", {15'b0, busy[0]}, 16'd0);
    check("reset_mdr",  bus_out[0],       16'h0000);
    rst = 0;
    tick;

    // T1 store plus known background words
    store(8'h12, 16'hBEEF);
    store(8'h20, 16'h1111);
    store(8'h31, 16'h2222);
    store(8'h41, 16'h3333);

    // T2 load and bus drive
    load(8'h12, 16'hBEEF, "t2_load");
    check("t2_drive", {15'b0, bus_drive[0]}, 16'd1);
    MDR_out = 0; #1;
    check("t2_undriven", bus_out[0], 16'h0000);
    check("t2_drive_off", {15'b0, bus_drive[0]}, 16'd0);
    MDR_out = 1;
    tick;

    // T3 abort after one BUSY edge
    set_mar(8'h20); set_mdr(16'h1234);
    mem_EN = 1; mem_RW = 0; tick; tick;
    mem_EN = 0; tick;
    check("t3_busy", {15'b0, busy[0]}, 16'd0);
    repeat (5) begin
      tick;
      check("t3_no_mfc", {15'b0, mfc[0]}, 16'd0);
    end
    load(8'h20, 16'h1111, "t3_ram_kept");

    // T4 snapshot: MAR/MDR change while BUSY
    begin
      int k;
      set_mar(8'h30); set_mdr(16'h5555);
      mem_EN = 1; mem_RW = 0; tick;
      set_mar(8'h31); set_mdr(16'hAAAA);
      k = 0;
      while (!mfc[0] && k < 40) begin tick; k++; end
      check("t4_latency", 16'(k), 16'd1);
      mem_EN = 0; tick;
    end
    load(8'h30, 16'h5555, "t4_snap_addr");
    load(8'h31, 16'h2222, "t4_other_kept");

    // T5 strobe priority, then reset mid-BUSY
    store(8'h40, 16'h0F0F);
    load(8'h40, 16'h0F0F, "t5_rdata");
    set_mdr(16'h1234);
    check("t5_mdr_write", bus_out[0], 16'h1234);
    bus_in = 16'hF0F0; MDR_EN_read = 1; MDR_EN_write = 1; tick;
    MDR_EN_read = 0; MDR_EN_write = 0;
    check("t5_priority", bus_out[0], 16'h0F0F);
    set_mar(8'h41); set_mdr(16'h9999);
    mem_EN = 1; mem_RW = 0; tick; tick;
    rst = 1; #1;
    check("t5_rst_mfc",  {15'b0, mfc[0]},  16'd0);
    check("t5_rst_busy", {15'b0, busy[0]}, 16'd0);
    check("t5_rst_mdr",  bus_out[0],       16'h0000);
    mem_EN = 0; tick;
    rst = 0; tick;
    // MAR was cleared: an access without loading MAR targets address 0
    set_mdr(16'h7777); access(0);
    load(8'h00, 16'h7777, "t5_mar_zero");
    load(8'h41, 16'h3333, "t5_no_write");

    // Reset while DONE drops MFC without a clock edge
    begin
      int k;
      set_mar(8'h12);
      mem_EN = 1; mem_RW = 1; tick;
      k = 0;
      while (!mfc[0] && k < 40) begin tick; k++; end
      check("done_mfc", {15'b0, mfc[0]}, 16'd1);
      #2 rst = 1; #1;
      check("done_rst_mfc", {15'b0, mfc[0]}, 16'd0);
      mem_EN = 0; tick;
      rst = 0; tick;
    end

    // T6 latency sweep across the three instances
    set_mar(8'h50); set_mdr(16'h6060);
    sweep(0);
    set_mdr(16'h0000);
    sweep(1);
    check("t6_load_lat3",  bus_out[0], 16'h6060);
    check("t6_load_lat1",  bus_out[1], 16'h6060);
    check("t6_load_lat15", bus_out[2], 16'h6060);

    tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
